// File: rtl/barret_inv_1453.sv
// barret_inv_1453: modular inverse modulo 1453 using Fermat's little theorem.
// The block computes a^1451 mod 1453 by square-and-multiply, scanning the
// exponent MSB-first. It performs one modular multiply per cycle, and the
// reduction uses the Barrett method. Operands and results are exchanged
// through valid/ready handshakes.
module barret_inv_1453 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] din_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] dout_r,
    output logic        dout_err
);
    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    localparam logic [10:0] EXP     = 11'd1451;   // 0b10110101011
    localparam logic [10:0] MOD11   = 11'd1453;
    localparam logic [23:0] MOD     = 24'd1453;
    localparam logic [23:0] BARRETT = 24'd2886;   // floor(2^22 / 1453)

    state_t      state_q, state_d;
    logic [10:0] a_q, a_d;
    logic [10:0] acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic [10:0] dout_r_q, dout_r_d;
    logic        dout_err_q, dout_err_d;

    logic [10:0] op_b;
    logic [23:0] x, t, r0, r1, r2;
    logic [10:0] mul_res;
    logic        last_step;

    // Shared multiplier and Barrett reduction. Because t never overestimates
    // the quotient, r0 >= 0, and at most three subtractions bring it below 1453.
    always_comb begin
        op_b    = (state_q == MUL) ? a_q : acc_q;
        x       = 24'(acc_q) * 24'(op_b);
        t       = ((x >> 11) * BARRETT) >> 11;
        r0      = x - t * MOD;
        r1      = (r0 >= MOD) ? r0 - MOD : r0;
        r2      = (r1 >= MOD) ? r1 - MOD : r1;
        mul_res = 11'((r2 >= MOD) ? r2 - MOD : r2);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers: operand, accumulator, bit index and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            acc_q      <= '0;
            idx_q      <= 4'd10;
            dout_r_q   <= '0;
            dout_err_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            dout_r_q   <= dout_r_d;
            dout_err_q <= dout_err_d;
        end
    end

    // A step finishes the exponent when bit 0 has been handled: a MUL step,
    // or a SQR step on a zero bit
    always_comb begin
        last_step = (idx_q == 4'd0) &&
                    ((state_q == MUL) || (state_q == SQR && !EXP[idx_q]));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)  state_d = SQR;
            SQR:  if (EXP[idx_q]) state_d = MUL;
                  else if (last_step) state_d = DONE;
            MUL:  if (last_step) state_d = DONE;
                  else           state_d = SQR;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Datapath updates. The result is latched on the final step so that it
    // stays stable throughout DONE.
    always_comb begin
        a_d        = a_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        dout_r_d   = dout_r_q;
        dout_err_d = dout_err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d   = (din_a >= MOD11) ? din_a - MOD11 : din_a;
                acc_d = 11'd1;
                idx_d = 4'd10;
            end
            SQR, MUL: begin
                acc_d = mul_res;
                if (last_step) begin
                    dout_r_d   = mul_res;
                    dout_err_d = (a_q == 11'd0);
                end else if (state_q == MUL || !EXP[idx_q]) begin
                    idx_d = idx_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        dout_r    = dout_r_q;
        dout_err  = dout_err_q;
    end
endmodule

// File: tb/tb_barret_inv_1453.sv
// Scoreboard bench for barret_inv_1453: the driver pushes the expected result
// on each accept, and the monitor pops and compares it on each handoff.
module tb_barret_inv_1453;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, dout_err;
    logic [10:0] din_a, dout_r;

    barret_inv_1453 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din_a(din_a), .out_valid(out_valid), .out_ready(out_ready),
        .dout_r(dout_r), .dout_err(dout_err)
    );

    typedef struct {
        int a;
        int r;
        int err;
        bit prod;      // check a*r mod 1453 == 1 instead of a fixed r
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   sent = 0, delivered = 0;
    int   mode = 0;    // 0: out_ready=1, 1: random, 2: stall 5 cycles

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    endtask

    // out_ready generator, driven just after each rising edge
    initial begin
        int stall = 0;
        out_ready = 1;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0: out_ready = 1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid) begin
                        out_ready = (stall >= 5);
                        stall++;
                    end else begin
                        out_ready = 0;
                        stall = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: latency, stability, and scoreboard compare on each handoff
    initial begin
        bit prev_v = 0, post_hs = 0;
        int held_r = 0, held_e = 0, vcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0; post_hs = 0;
            end else begin
                if (post_hs) check("in_ready_after_handoff", in_ready, 1);
                post_hs = 0;
                if (out_valid) begin
                    if (!prev_v) begin
                        vcnt = 0;
                        held_r = dout_r; held_e = dout_err;
                        if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
                        else check("latency", cyc - sb[0].acc_cyc, 18);
                    end else begin
                        check("dout_r_stable", dout_r, held_r);
                        check("dout_err_stable", dout_err, held_e);
                    end
                    vcnt++;
                    check("in_ready_low_in_done", in_ready, 0);
                    if (out_ready && sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.prod) begin
                            check("inverse_product", (e.a * int'(dout_r)) % 1453, 1);
                        end else begin
                            check("dout_r", dout_r, e.r);
                        end
                        check("dout_err", dout_err, e.err);
                        if (mode == 2) check("stall_done_cycles", vcnt, 6);
                        delivered++;
                        post_hs = 1;
                    end
                end
                prev_v = out_valid;
            end
        end
    end

    // Sends one operand; the caller is positioned just after a rising edge
    task automatic send(input int a, input int er, input int ee, input bit prod);
        exp_t e;
        int w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            return;
        end
        in_valid = 1; din_a = 11'(a);
        @(posedge clk); #1;
        check("accepted", in_ready, 0);
        e.a = a; e.r = er; e.err = ee; e.prod = prod; e.acc_cyc = cyc;
        sb.push_back(e);
        sent++;
        // The busy block must ignore this operand
        din_a = 11'd5;
        @(posedge clk); #1;
        in_valid = 0;
        din_a = 11'($urandom);
    endtask

    initial begin
        int w;
        rst_n = 0; in_valid = 0; din_a = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dout_r", dout_r, 0);
        check("rst_dout_err", dout_err, 0);
        rst_n = 1;

        // Directed vectors with hand-computed inverses
        send(2,    727,  0, 0);
        send(3,    969,  0, 0);
        send(1,    1,    0, 0);
        send(1452, 1452, 0, 0);
        send(1455, 727,  0, 0);
        send(0,    0,    1, 0);
        send(1453, 0,    1, 0);

        // Five-cycle downstream stall in DONE
        mode = 2;
        send(3, 969, 0, 0);
        w = 0;
        while (sb.size() > 0 && w < 200) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        mode = 0;

        // Abort mid-computation; this operand must never be delivered
        w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        in_valid = 1; din_a = 11'd2;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_dout_r", dout_r, 0);
        in_valid = 1; din_a = 11'd2;
        @(posedge clk); #1;
        rst_n = 1;
        // The first edge after release must accept
        @(posedge clk); #1;
        check("accept_first_edge", in_ready, 0);
        begin
            exp_t e;
            e.a = 2; e.r = 727; e.err = 0; e.prod = 0; e.acc_cyc = cyc;
            sb.push_back(e);
            sent++;
        end
        in_valid = 0;

        // Sweep every invertible operand with random stalls
        mode = 1;
        for (int a = 1; a <= 1452; a++) send(a, 0, 0, 1);

        w = 0;
        while (sb.size() > 0 && w < 2000) begin @(posedge clk); #1; w++; end
        repeat (30) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        check("delivered_once", delivered, sent);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
